// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
//  Shared types and helpers for the LCD timing / test-pattern generator.
//  - mode_e     : run-time pattern selector
//  - bar_color  : 8-entry colour-bar table as {R,G,B} on/off bits
//  - total_len  : sync + back + active + front
//  - cnt_width  : counter width able to index 0..n-1 (at least 1 bit)
// ----------------------------------------------------------------------------
package lcd_pkg;

   typedef enum logic [1:0] {
      MODE_BARS    = 2'd0,
      MODE_CHECKER = 2'd1,
      MODE_RAMP    = 2'd2,
      MODE_SOLID   = 2'd3
   } mode_e;

   // Each bit selects full scale (1) or zero (0) for one channel: {R,G,B}.
   function automatic logic [2:0] bar_color(input logic [2:0] idx);
      logic [2:0] rgb;
      case (idx)
         3'd0:    rgb = 3'b111;  // white
         3'd1:    rgb = 3'b110;  // yellow
         3'd2:    rgb = 3'b011;  // cyan
         3'd3:    rgb = 3'b010;  // green
         3'd4:    rgb = 3'b101;  // magenta
         3'd5:    rgb = 3'b100;  // red
         3'd6:    rgb = 3'b001;  // blue
         default: rgb = 3'b000;  // black
      endcase
      return rgb;
   endfunction

   function automatic int total_len(input int sync_len, input int back_len,
                                    input int active_len, input int front_len);
      return sync_len + back_len + active_len + front_len;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lcd_timing_ctr.sv
// ----------------------------------------------------------------------------
// lcd_timing_ctr
//  Free-running horizontal/vertical pixel counters plus combinational decode
//  of the raw (unregistered) panel timing for the current counter position.
//  Line/frame order: sync, back porch, active, front porch.
//  Ports:
//   clk_i, rst_ni       pixel clock, asynchronous active-low reset
//   hd_raw_o, vd_raw_o  active-low syncs for the current position
//   den_raw_o           current position is inside the visible area
//   frame_start_raw_o   counters are at hcnt=0, vcnt=0
//   x_o, y_o            active-area coordinates (zero outside active range)
// ----------------------------------------------------------------------------
module lcd_timing_ctr import lcd_pkg::*; #(
   parameter int H_ACTIVE = 800,
   parameter int H_FRONT  = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BACK   = 88,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 1,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 21,
   localparam int X_W     = cnt_width(H_ACTIVE),
   localparam int Y_W     = cnt_width(V_ACTIVE)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   output logic           hd_raw_o,
   output logic           vd_raw_o,
   output logic           den_raw_o,
   output logic           frame_start_raw_o,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o
);

   localparam int H_TOTAL = total_len(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
   localparam int V_TOTAL = total_len(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
   localparam int HC_W    = cnt_width(H_TOTAL);
   localparam int VC_W    = cnt_width(V_TOTAL);

   localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
   localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

   // Boundaries are compared at 32 bits so an end boundary equal to the
   // total (zero front porch) cannot overflow the counter width.
   localparam logic [31:0] H_SYNC_END  = 32'(H_SYNC);
   localparam logic [31:0] H_ACT_START = 32'(H_SYNC + H_BACK);
   localparam logic [31:0] H_ACT_END   = 32'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [31:0] V_SYNC_END  = 32'(V_SYNC);
   localparam logic [31:0] V_ACT_START = 32'(V_SYNC + V_BACK);
   localparam logic [31:0] V_ACT_END   = 32'(V_SYNC + V_BACK + V_ACTIVE);

   logic [HC_W-1:0] hcnt_q, hcnt_d;
   logic [VC_W-1:0] vcnt_q, vcnt_d;
   logic [31:0]     h_ext, v_ext;
   logic            h_act, v_act;

   always_comb begin
      hcnt_d = hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   always_comb begin
      h_ext             = 32'(hcnt_q);
      v_ext             = 32'(vcnt_q);
      h_act             = (h_ext >= H_ACT_START) && (h_ext < H_ACT_END);
      v_act             = (v_ext >= V_ACT_START) && (v_ext < V_ACT_END);
      hd_raw_o          = !(h_ext < H_SYNC_END);
      vd_raw_o          = !(v_ext < V_SYNC_END);
      den_raw_o         = h_act && v_act;
      frame_start_raw_o = (hcnt_q == '0) && (vcnt_q == '0);
      x_o               = h_act ? X_W'(h_ext - H_ACT_START) : '0;
      y_o               = v_act ? Y_W'(v_ext - V_ACT_START) : '0;
   end

endmodule

// File: rtl/lcd_pattern_gen.sv
// ----------------------------------------------------------------------------
// lcd_pattern_gen
//  Parametrised LCD timing and test-pattern generator for an RGB parallel
//  panel. Pattern mode and solid colour are latched once per frame so a
//  change never tears an image.
//  Ports:
//   clk_i          pixel clock
//   rst_ni         asynchronous active-low reset
//   mode_i         0 bars, 1 checker, 2 grey ramp, 3 solid (sampled at frame start)
//   solid_rgb_i    {R,G,B} for solid mode (sampled at frame start)
//   nclk_o         panel clock, inverted pixel clock
//   grest_o        panel reset, follows rst_ni
//   hd_o, vd_o     active-low horizontal / vertical sync
//   den_o          data enable, high on visible pixels
//   r_o, g_o, b_o  pixel data, zero outside the visible area
//   frame_start_o  one-cycle pulse on the first output cycle of each frame
// ----------------------------------------------------------------------------
module lcd_pattern_gen import lcd_pkg::*; #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FRONT    = 40,
   parameter int H_SYNC     = 128,
   parameter int H_BACK     = 88,
   parameter int V_ACTIVE   = 480,
   parameter int V_FRONT    = 1,
   parameter int V_SYNC     = 3,
   parameter int V_BACK     = 21,
   parameter int COLOR_W    = 8,
   parameter int NUM_BARS   = 8,
   parameter int CHECK_LOG2 = 5,
   parameter int RAMP_SHIFT = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [1:0]           mode_i,
   input  logic [3*COLOR_W-1:0] solid_rgb_i,
   output logic                 nclk_o,
   output logic                 grest_o,
   output logic                 hd_o,
   output logic                 vd_o,
   output logic                 den_o,
   output logic [COLOR_W-1:0]   r_o,
   output logic [COLOR_W-1:0]   g_o,
   output logic [COLOR_W-1:0]   b_o,
   output logic                 frame_start_o
);

   localparam int X_W   = cnt_width(H_ACTIVE);
   localparam int Y_W   = cnt_width(V_ACTIVE);
   localparam int BAR_W = H_ACTIVE / NUM_BARS;
   localparam int BC_W  = cnt_width(BAR_W);

   localparam logic [BC_W-1:0] BAR_LAST = BC_W'(BAR_W - 1);
   localparam logic [2:0]      BAR_MAX  = 3'(NUM_BARS - 1);

   assign nclk_o  = ~clk_i;
   assign grest_o = rst_ni;

   // ---------------------------------------------------------------- timing
   logic           hd_raw, vd_raw, den_raw, fs_raw;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;

   lcd_timing_ctr #(
      .H_ACTIVE (H_ACTIVE),
      .H_FRONT  (H_FRONT),
      .H_SYNC   (H_SYNC),
      .H_BACK   (H_BACK),
      .V_ACTIVE (V_ACTIVE),
      .V_FRONT  (V_FRONT),
      .V_SYNC   (V_SYNC),
      .V_BACK   (V_BACK)
   ) u_timing (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .hd_raw_o          (hd_raw),
      .vd_raw_o          (vd_raw),
      .den_raw_o         (den_raw),
      .frame_start_raw_o (fs_raw),
      .x_o               (x),
      .y_o               (y)
   );

   // ------------------------------------------------------------ mode latch
   // The frame-start cycle already uses the freshly sampled values, so even a
   // zero-porch timing whose first pixel is visible gets the new mode.
   mode_e                mode_q, mode_d;
   logic [3*COLOR_W-1:0] solid_q, solid_d;

   always_comb begin
      mode_d  = mode_q;
      solid_d = solid_q;
      if (fs_raw) begin
         mode_d  = mode_e'(mode_i);
         solid_d = solid_rgb_i;
      end
   end

   // ----------------------------------------------------------- bar counter
   // Pixel counter within the current bar plus a saturating bar index; both
   // restart at x=0 so the last bar absorbs any H_ACTIVE/NUM_BARS remainder.
   logic [2:0]      bar_idx_q, bar_idx_d, bar_idx_cur;
   logic [BC_W-1:0] bar_cnt_q, bar_cnt_d, bar_cnt_cur;
   logic            bar_first;

   always_comb begin
      bar_first   = den_raw && (x == '0);
      bar_idx_cur = bar_first ? '0 : bar_idx_q;
      bar_cnt_cur = bar_first ? '0 : bar_cnt_q;
      bar_idx_d   = bar_idx_q;
      bar_cnt_d   = bar_cnt_q;
      if (den_raw) begin
         if (bar_cnt_cur == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = (bar_idx_cur == BAR_MAX) ? bar_idx_cur : bar_idx_cur + 3'd1;
         end else begin
            bar_cnt_d = bar_cnt_cur + 1'b1;
            bar_idx_d = bar_idx_cur;
         end
      end
   end

   // ----------------------------------------------------------- pattern mux
   logic [2:0]         bar_rgb;
   logic               checker_dark;
   logic [COLOR_W-1:0] ramp;
   logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

   always_comb begin
      bar_rgb      = bar_color(bar_idx_cur);
      checker_dark = (((32'(x) >> CHECK_LOG2) ^ (32'(y) >> CHECK_LOG2)) & 32'd1) != 32'd0;
      ramp         = COLOR_W'(32'(x) >> RAMP_SHIFT);
      pix_r        = '0;
      pix_g        = '0;
      pix_b        = '0;
      if (den_raw) begin
         case (mode_d)
            MODE_BARS: begin
               pix_r = {COLOR_W{bar_rgb[2]}};
               pix_g = {COLOR_W{bar_rgb[1]}};
               pix_b = {COLOR_W{bar_rgb[0]}};
            end
            MODE_CHECKER: begin
               if (!checker_dark) begin
                  pix_r = '1;
                  pix_g = '1;
                  pix_b = '1;
               end
            end
            MODE_RAMP: begin
               pix_r = ramp;
               pix_g = ramp;
               pix_b = ramp;
            end
            MODE_SOLID: begin
               {pix_r, pix_g, pix_b} = solid_d;
            end
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------- output stage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q        <= MODE_BARS;
         solid_q       <= '0;
         bar_idx_q     <= '0;
         bar_cnt_q     <= '0;
         hd_o          <= 1'b1;
         vd_o          <= 1'b1;
         den_o         <= 1'b0;
         r_o           <= '0;
         g_o           <= '0;
         b_o           <= '0;
         frame_start_o <= 1'b0;
      end else begin
         mode_q        <= mode_d;
         solid_q       <= solid_d;
         bar_idx_q     <= bar_idx_d;
         bar_cnt_q     <= bar_cnt_d;
         hd_o          <= hd_raw;
         vd_o          <= vd_raw;
         den_o         <= den_raw;
         r_o           <= pix_r;
         g_o           <= pix_g;
         b_o           <= pix_b;
         frame_start_o <= fs_raw;
      end
   end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
module tb_lcd_pattern_gen;

   localparam int H_ACTIVE = 16, H_FRONT = 2, H_SYNC = 4, H_BACK = 2;
   localparam int V_ACTIVE = 8,  V_FRONT = 1, V_SYNC = 2, V_BACK = 1;
   localparam int CW = 8, NB = 4, CL = 1, RS = 0;
   localparam int HT = 24, VT = 12, FRAME = HT * VT;
   localparam int HA0 = H_SYNC + H_BACK;  // first active column
   localparam int VA0 = V_SYNC + V_BACK;  // first active line

   typedef struct packed {
      logic          hd;
      logic          vd;
      logic          den;
      logic          fs;
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } pix_t;

   localparam pix_t RESET_PIX = '{hd: 1'b1, vd: 1'b1, den: 1'b0, fs: 1'b0, r: '0, g: '0, b: '0};

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      mode = 2'd0;
   logic [3*CW-1:0] solid = '0;
   logic            nclk_o, grest_o, hd_o, vd_o, den_o, fs_o;
   logic [CW-1:0]   r_o, g_o, b_o;

   int   total = 0;
   int   bad = 0;
   pix_t sb_q[$];
   pix_t seen[FRAME];

   lcd_pattern_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
      .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
      .COLOR_W(CW), .NUM_BARS(NB), .CHECK_LOG2(CL), .RAMP_SHIFT(RS)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .solid_rgb_i(solid),
      .nclk_o(nclk_o), .grest_o(grest_o), .hd_o(hd_o), .vd_o(vd_o), .den_o(den_o),
      .r_o(r_o), .g_o(g_o), .b_o(b_o), .frame_start_o(fs_o)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] bar_ref(input int bar);
      case (bar)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic pix_t obs();
      return {hd_o, vd_o, den_o, fs_o, r_o, g_o, b_o};
   endfunction

   // Reference model: on each active edge, push the pixel the DUT must show
   // for the counter position it is at, then advance the model counters.
   int              m_h = 0;
   int              m_v = 0;
   logic [1:0]      m_mode = 2'd0;
   logic [3*CW-1:0] m_solid = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_h     <= 0;
         m_v     <= 0;
         m_mode  <= 2'd0;
         m_solid <= '0;
         sb_q.delete();
      end else begin
         automatic pix_t            e = '0;
         automatic int              x = m_h - HA0;
         automatic int              y = m_v - VA0;
         automatic logic            fs = (m_h == 0) && (m_v == 0);
         automatic logic [1:0]      md = fs ? mode : m_mode;
         automatic logic [3*CW-1:0] sc = fs ? solid : m_solid;
         automatic int              bar;
         e.hd  = (m_h >= H_SYNC);
         e.vd  = (m_v >= V_SYNC);
         e.fs  = fs;
         e.den = (m_h >= HA0) && (m_h < HA0 + H_ACTIVE) && (m_v >= VA0) && (m_v < VA0 + V_ACTIVE);
         if (e.den) begin
            case (md)
               2'd0: begin
                  bar = x / (H_ACTIVE / NB);
                  if (bar > NB - 1) bar = NB - 1;
                  {e.r, e.g, e.b} = bar_ref(bar);
               end
               2'd1: if ((((x >> CL) ^ (y >> CL)) & 1) == 0) {e.r, e.g, e.b} = 24'hFFFFFF;
               2'd2: begin
                  e.r = 8'(x >> RS);
                  e.g = 8'(x >> RS);
                  e.b = 8'(x >> RS);
               end
               default: {e.r, e.g, e.b} = sc;
            endcase
         end
         sb_q.push_back(e);
         if (fs) begin
            m_mode  <= mode;
            m_solid <= solid;
         end
         if (m_h == HT - 1) begin
            m_h <= 0;
            m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
         end else begin
            m_h <= m_h + 1;
         end
      end
   end

   // Advance n cycles, comparing every output cycle against the scoreboard.
   task automatic step(input string tag, input int n);
      pix_t o, e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         o = obs();
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s sb_empty cyc=%0d got=%h", tag, i, o);
         end else begin
            e = sb_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL %s cyc=%0d got=%h exp=%h", tag, i, o, e);
            end
         end
         if (i < FRAME) seen[i] = o;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (obs() !== RESET_PIX) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), RESET_PIX);
         end
         total++;
         if (grest_o !== 1'b0 || nclk_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_grest_nclk got=%b%b exp=01", grest_o, nclk_o);
         end
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (grest_o !== 1'b1) begin
         bad++;
         $display("FAIL grest_release got=%b exp=1", grest_o);
      end
      $display("test_reset done");
   endtask

   // Cold-start frame in bar mode: sync widths, periods, DEN count, bars.
   task automatic test_timing_bars(input string tag);
      int den_cnt, fs_cnt, hd_low, vd_low;
      step(tag, FRAME);
      den_cnt = 0; fs_cnt = 0; hd_low = 0; vd_low = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (seen[i].den) den_cnt++;
         if (seen[i].fs) fs_cnt++;
         if (!seen[i].vd) vd_low++;
         if (i < HT && !seen[i].hd) hd_low++;
      end
      total++;
      if (den_cnt != H_ACTIVE * V_ACTIVE) begin
         bad++;
         $display("FAIL %s den_count got=%0d exp=%0d", tag, den_cnt, H_ACTIVE * V_ACTIVE);
      end
      total++;
      if (fs_cnt != 1 || seen[0].fs !== 1'b1) begin
         bad++;
         $display("FAIL %s frame_start got=%0d first=%b exp=1 first=1", tag, fs_cnt, seen[0].fs);
      end
      total++;
      if (hd_low != H_SYNC || seen[HT].hd !== 1'b0 || seen[HT + H_SYNC].hd !== 1'b1) begin
         bad++;
         $display("FAIL %s hd_pulse got=%0d exp=%0d", tag, hd_low, H_SYNC);
      end
      total++;
      if (vd_low != V_SYNC * HT) begin
         bad++;
         $display("FAIL %s vd_pulse got=%0d exp=%0d", tag, vd_low, V_SYNC * HT);
      end
      $display("%s done den=%0d fs=%0d hd_low=%0d", tag, den_cnt, fs_cnt, hd_low);
   endtask

   task automatic test_bars();
      logic [23:0] exp_bar[4] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00};
      test_timing_bars("bars_frame");
      for (int x = 0; x < H_ACTIVE; x++) begin
         pix_t p = seen[VA0 * HT + HA0 + x];
         total++;
         if ({p.r, p.g, p.b} !== exp_bar[x / 4]) begin
            bad++;
            $display("FAIL bars x=%0d got=%h exp=%h", x, {p.r, p.g, p.b}, exp_bar[x / 4]);
         end
      end
      $display("test_bars done");
   endtask

   task automatic test_ramp();
      mode = 2'd2;
      step("ramp_frame", FRAME);
      for (int i = 0; i < FRAME; i++) begin
         int h = i % HT;
         total++;
         if (seen[i].den) begin
            if (seen[i].r !== 8'(h - HA0) || seen[i].g !== 8'(h - HA0) || seen[i].b !== 8'(h - HA0)) begin
               bad++;
               $display("FAIL ramp i=%0d got=%h%h%h exp=%h", i, seen[i].r, seen[i].g, seen[i].b, 8'(h - HA0));
            end
         end else if ({seen[i].r, seen[i].g, seen[i].b} !== 24'h0) begin
            bad++;
            $display("FAIL ramp_blank i=%0d got=%h%h%h exp=000000", i, seen[i].r, seen[i].g, seen[i].b);
         end
      end
      $display("test_ramp done");
   endtask

   task automatic test_checker();
      int          xs[4] = '{0, 2, 2, 1};
      int          ys[4] = '{0, 0, 2, 3};
      logic [23:0] ex[4] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
      mode = 2'd1;
      step("checker_frame", FRAME);
      for (int k = 0; k < 4; k++) begin
         pix_t p = seen[(VA0 + ys[k]) * HT + HA0 + xs[k]];
         total++;
         if (p.den !== 1'b1 || {p.r, p.g, p.b} !== ex[k]) begin
            bad++;
            $display("FAIL checker x=%0d y=%0d got=%h exp=%h", xs[k], ys[k], {p.r, p.g, p.b}, ex[k]);
         end
      end
      $display("test_checker done");
   endtask

   task automatic test_solid_midframe();
      int hits;
      step("solid_pre", 100);
      mode  = 2'd3;
      solid = 24'h123456;
      step("solid_rest", FRAME - 100);
      hits = 0;
      for (int i = 0; i < FRAME - 100; i++)
         if (seen[i].den && {seen[i].r, seen[i].g, seen[i].b} === 24'h123456) hits++;
      total++;
      if (hits != 0) begin
         bad++;
         $display("FAIL solid_midframe_ignored got=%0d exp=0", hits);
      end
      step("solid_frame", FRAME);
      hits = 0;
      for (int i = 0; i < FRAME; i++)
         if (seen[i].den && {seen[i].r, seen[i].g, seen[i].b} === 24'h123456) hits++;
      total++;
      if (hits != H_ACTIVE * V_ACTIVE) begin
         bad++;
         $display("FAIL solid_next_frame got=%0d exp=%0d", hits, H_ACTIVE * V_ACTIVE);
      end
      $display("test_solid_midframe done hits=%0d", hits);
   endtask

   task automatic test_reset_midframe();
      step("pre_reset", 50);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (obs() !== RESET_PIX) begin
         bad++;
         $display("FAIL async_reset got=%h exp=%h", obs(), RESET_PIX);
      end
      @(negedge clk);
      total++;
      if (obs() !== RESET_PIX || grest_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold got=%h exp=%h", obs(), RESET_PIX);
      end
      rst_n = 1'b1;
      test_timing_bars("restart_frame");
      step("next_start", 1);
      total++;
      if (seen[0].fs !== 1'b1) begin
         bad++;
         $display("FAIL restart_next_fs got=%b exp=1", seen[0].fs);
      end
      $display("test_reset_midframe done");
   endtask

   initial begin
      test_reset();
      test_bars();
      test_ramp();
      test_checker();
      test_solid_midframe();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
